video_mem_arbiter: RTL
======================

# video_mem_arbiter

Single-port video RAM responder serving the VGA generator's 16-clock fetch requests and the CPU bus on one synchronous RAM. A video fetch always completes with a fixed 3-cycle latency, so `vga_data` is stable when the generator loads its pixel shifter. CPU reads and writes fill the remaining slots. The block sits between the VGA generator, the CPU bus decoder and the video block RAM.

## Interface
Parameters:
- `ADDR_W`, 13: video RAM address width (8 KB).
- `DATA_W`, 8: RAM data width.

Ports:
- `clk` in 1: pixel clock (65 MHz).
- `reset` in 1: asynchronous, active-high.
- `vga_req` in 1: one-cycle fetch strobe from the generator (nibble phase 12).
- `vga_address` in `ADDR_W`: fetch address, valid with `vga_req`.
- `vga_data` out `DATA_W`: last fetched video byte, held between fetches.
- `vga_overrun` out 1: sticky flag, video request arrived too early.
- `cpu_req` in 1: level request, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write, 0 = read; valid with `cpu_req`.
- `cpu_address` in `ADDR_W`: CPU address.
- `cpu_din` in `DATA_W`: CPU write data.
- `cpu_dout` out `DATA_W`: CPU read data, valid in the `cpu_ack` cycle and held afterwards.
- `cpu_ack` out 1: one-cycle completion pulse.
- `mem_en` out 1: RAM access strobe.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out `ADDR_W`: RAM address.
- `mem_wdata` out `DATA_W`: RAM write data.
- `mem_rdata` in `DATA_W`: RAM read data, valid 1 cycle after the `mem_en` read cycle.

## Operation
- **Two-stage pipeline.**
  - Issue stage: registered `mem_*` outputs plus a tag from {NONE, VID, CPU_RD, CPU_WR}.
  - Capture stage: the tag delayed one cycle.
  - A new access can issue every cycle.
- **Issue decision** is made from inputs sampled in cycle T; the access drives the RAM in cycle T+1.
  - `vga_req` = 1: issue VID with `mem_addr = vga_address`, `mem_we` = 0. Video has absolute priority.
  - Else `cpu_req` = 1 and `cpu_busy` = 0: issue CPU_RD or CPU_WR and set `cpu_busy`. Address and data are latched from the `cpu_*` inputs.
  - Else NONE: `mem_en` = 0. `mem_addr` and `mem_wdata` hold their values.
- **Capture.**
  - Tag VID: `vga_data` <= `mem_rdata`.
  - Tag CPU_RD: `cpu_dout` <= `mem_rdata`, then `cpu_ack` pulses.
- **CPU write.** `cpu_ack` pulses the cycle after the write issue cycle.
- **`cpu_busy`** clears in the `cpu_ack` cycle. If `cpu_req` is still high in that cycle, it is treated as a new request and issues at ack+1 at the earliest.
- **Overrun.** `vga_req` within 2 cycles of the previous `vga_req` (a VID already in issue or capture) sets `vga_overrun`. The new fetch still issues. `vga_overrun` clears only on reset.
- **CPU blocked by video.** A CPU request arriving in the same cycle as `vga_req` is delayed exactly one cycle. It is never dropped.

## Timing
- **Video latency.** `vga_req` in cycle T:
  - `mem_en` in T+1.
  - `mem_rdata` valid in T+2.
  - `vga_data` updated and valid from T+3, which is the generator's nibble phase 15 load cycle.
- **CPU read.** Request seen in cycle C, no contention:
  - Issue in C+1.
  - `cpu_ack` and `cpu_dout` in C+3.
  - Worst case with a video collision: `cpu_ack` in C+4.
- **CPU write.** Issue in C+1, `cpu_ack` in C+2. The RAM is written at the end of C+1.
- **Reset values.** All outputs 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `vga_data`, `vga_overrun`, `cpu_dout`, `cpu_ack`. Tags become NONE and `cpu_busy` = 0.
- **Reset mid-operation.** In-flight accesses are discarded and no `cpu_ack` is issued for them. A write already in its issue cycle may or may not land in RAM.
- **Read/write hazard.** A CPU write at address A, followed by a video read of A issued in the next cycle, returns the new data (RAM read-after-write order is preserved).

## Structure
- Package `video_mem_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults.
  - Tag enum `mem_tag_t` {TAG_NONE, TAG_VID, TAG_CPU_RD, TAG_CPU_WR}.
  - Constant `VID_LATENCY = 3`, shared with the VGA generator's assertions.
- Single module; no sub-module is warranted. The bench provides a 1-cycle-latency RAM model.

## Test plan
- **Isolated video read.** RAM[0x0123] = 0xA5; `vga_req` with address 0x0123 in cycle 10 -> `mem_en` in 11, `vga_data` = 0xA5 from 13; `vga_overrun` stays 0.
- **CPU write then read.** Write 0x3C to 0x1FFF, then read 0x1FFF -> first `cpu_ack` 2 cycles after request, second `cpu_ack` 3 cycles after its request, `cpu_dout` = 0x3C.
- **Collision.** `cpu_req` (read of 0x0040 = 0x77) and `vga_req` (0x0041 = 0x11) in the same cycle T:
  - VID issues in T+1 and CPU_RD in T+2.
  - `vga_data` = 0x11 at T+3; `cpu_ack` with 0x77 at T+4.
- **Steady raster.** `vga_req` every 16 cycles for 64 fetches, with random CPU traffic on every free cycle -> every `vga_data` update exactly 3 cycles after its request, every `cpu_ack` within 4 cycles of its request, no lost CPU transaction.
- **Overrun.** `vga_req` in cycles 20 and 22 -> `vga_overrun` = 1 from cycle 23 and stays 1; both fetches return their correct data.
- **Reset mid-read.** Assert `reset` one cycle after a CPU read issues -> no `cpu_ack`, all outputs 0. After release, a new CPU read completes normally.

Source files
------------

// File: rtl/video_mem_pkg.sv
// Shared constants and access tags for the video RAM arbiter and the VGA generator.
package video_mem_pkg;

  localparam int ADDR_W      = 13;
  localparam int DATA_W      = 8;
  localparam int VID_LATENCY = 3;

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_VID,
    TAG_CPU_RD,
    TAG_CPU_WR
  } mem_tag_t;

endpackage

// File: rtl/video_mem_arbiter.sv
// Single-port video RAM responder: fixed-latency video fetches with absolute
// priority, CPU reads/writes in the remaining slots, one access issued per cycle.
module video_mem_arbiter #(
  parameter int ADDR_W = video_mem_pkg::ADDR_W,
  parameter int DATA_W = video_mem_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_address,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  import video_mem_pkg::*;

  mem_tag_t issue_tag;
  mem_tag_t cap_tag;
  logic     cpu_busy;
  logic     ack_due;
  logic     vid_in_flight;

  // A write acks straight out of its issue cycle; a read acks once its data is captured.
  assign ack_due       = (issue_tag == TAG_CPU_WR) || (cap_tag == TAG_CPU_RD);
  assign vid_in_flight = (issue_tag == TAG_VID) || (cap_tag == TAG_VID);

  // Issue stage: decides the access from this cycle's inputs and drives the RAM next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_tag   <= TAG_NONE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_busy    <= 1'b0;
      vga_overrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every test below sees the pre-edge state.
      if (vga_req && vid_in_flight) vga_overrun <= 1'b1;
      // busy drops into the ack cycle; a still-high cpu_req there counts as a new request
      if (ack_due) cpu_busy <= 1'b0;

      if (vga_req) begin
        issue_tag <= TAG_VID;
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= vga_address;
      end else if (cpu_req && !cpu_busy) begin
        issue_tag <= cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
        mem_en    <= 1'b1;
        mem_we    <= cpu_we;
        mem_addr  <= cpu_address;
        mem_wdata <= cpu_din;
        cpu_busy  <= 1'b1;
      end else begin
        issue_tag <= TAG_NONE;
        mem_en    <= 1'b0;
        mem_we    <= 1'b0;
      end
    end
  end

  // Capture stage: the tag trails the RAM access by one cycle, aligned with mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_tag  <= TAG_NONE;
      vga_data <= '0;
      cpu_dout <= '0;
      cpu_ack  <= 1'b0;
    end else begin
      cap_tag <= issue_tag;
      cpu_ack <= ack_due;
      if (cap_tag == TAG_VID)    vga_data <= mem_rdata;
      if (cap_tag == TAG_CPU_RD) cpu_dout <= mem_rdata;
    end
  end

endmodule
